// File: rtl/mem_arbiter_pkg.sv
// Shared types for the unified-memory arbiter: FSM state, grant encoding, latency bound.
package mem_arb_pkg;
  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;
  typedef enum logic {GNT_I, GNT_D} arb_gnt_t;
  localparam int MAX_MEM_LATENCY = 4;
endpackage

// File: rtl/mem_arbiter_if.sv
// CPU fetch/data ports and the single memory port, bundled; slave = arbiter view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ready;
  logic              i_rvalid;
  logic [DATA_W-1:0] i_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ready;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_ready, i_rvalid, i_rdata, d_ready, d_rvalid, d_rdata,
           mem_req, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_ready, i_rvalid, i_rdata, d_ready, d_rvalid, d_rdata,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter_rr2.sv
// Two-way round-robin picker; on a tie the port not granted last time wins.
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic     req_i,
  input  logic     req_d,
  input  arb_gnt_t last,
  output arb_gnt_t gnt
);
  always_comb begin
    gnt = GNT_I;
    if (req_i && req_d) gnt = (last == GNT_I) ? GNT_D : GNT_I;
    else if (req_d)     gnt = GNT_D;
  end
endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory shared by fetch and load/store: one transaction in flight,
// fixed-latency return, combinational accept from idle.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input logic          clk,
  input logic          n_reset,
  mem_arbiter_if.slave bus
);
  localparam int               CNT_W = $clog2(MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0] LAT   = CNT_W'(MEM_LATENCY);

  if (MEM_LATENCY < 1 || MEM_LATENCY > MAX_MEM_LATENCY) begin : g_lat_chk
    $error("mem_arbiter: MEM_LATENCY must be in 1..%0d", MAX_MEM_LATENCY);
  end

  arb_state_t        state_q, state_d;
  arb_gnt_t          gnt_q, gnt_d, last_q, last_d, pick;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              dwe_q, dwe_d;
  logic [DATA_W-1:0] irdata_q, irdata_d, drdata_q, drdata_d;
  logic [ADDR_W-1:0] addr_mux;
  logic              accept, done;

  arb_rr2 u_rr (.req_i(bus.i_req), .req_d(bus.d_req), .last(last_q), .gnt(pick));

  // Gating with n_reset keeps every output at its reset value while reset is held.
  assign accept = n_reset && (state_q == ARB_IDLE) && (bus.i_req || bus.d_req);
  assign done   = (state_q == ARB_BUSY) && (cnt_q == CNT_W'(1));

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    cnt_d    = (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
    dwe_d    = dwe_q;
    irdata_d = irdata_q;
    drdata_d = drdata_q;
    if (accept) begin
      state_d = ARB_BUSY;
      gnt_d   = pick;
      last_d  = pick;
      cnt_d   = LAT;
      dwe_d   = (pick == GNT_D) && bus.d_we;
    end
    if (done) begin
      state_d = ARB_IDLE;
      if (gnt_q == GNT_I) irdata_d = bus.mem_rdata;
      else                drdata_d = dwe_q ? '0 : bus.mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q  <= ARB_IDLE;
      gnt_q    <= GNT_I;
      last_q   <= GNT_I;
      cnt_q    <= '0;
      dwe_q    <= 1'b0;
      irdata_q <= '0;
      drdata_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      dwe_q    <= dwe_d;
      irdata_q <= irdata_d;
      drdata_q <= drdata_d;
    end
  end

  always_comb begin
    addr_mux = '0;
    if (accept) addr_mux = (pick == GNT_D) ? bus.d_addr : bus.i_addr;
  end

  assign bus.i_ready   = accept && (pick == GNT_I);
  assign bus.d_ready   = accept && (pick == GNT_D);
  assign bus.mem_req   = accept;
  assign bus.mem_we    = accept && (pick == GNT_D) && bus.d_we;
  assign bus.mem_addr  = addr_mux;
  assign bus.mem_wdata = (accept && (pick == GNT_D)) ? bus.d_wdata : '0;
  assign bus.i_rvalid  = done && (gnt_q == GNT_I);
  assign bus.d_rvalid  = done && (gnt_q == GNT_D);
  // Read data passes straight through in the rvalid cycle and is held afterwards.
  assign bus.i_rdata   = irdata_d;
  assign bus.d_rdata   = drdata_d;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: DUTs at latency 1 and 3, one active at a time, checked
// cycle by cycle against a transaction-timing model and a word-array memory.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic n_reset;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();
  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b3 ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) u_dut1 (
    .clk(clk), .n_reset(n_reset), .bus(b1.slave));
  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3)) u_dut3 (
    .clk(clk), .n_reset(n_reset), .bus(b3.slave));

  logic        sel3;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
  int          lat;
  assign lat = sel3 ? 3 : 1;

  assign b1.i_req = i_req & ~sel3;   assign b3.i_req = i_req & sel3;
  assign b1.d_req = d_req & ~sel3;   assign b3.d_req = d_req & sel3;
  assign b1.i_addr = i_addr;         assign b3.i_addr = i_addr;
  assign b1.d_addr = d_addr;         assign b3.d_addr = d_addr;
  assign b1.d_we = d_we;             assign b3.d_we = d_we;
  assign b1.d_wdata = d_wdata;       assign b3.d_wdata = d_wdata;
  assign b1.mem_rdata = mem_rdata;   assign b3.mem_rdata = mem_rdata;

  logic        o_i_ready, o_d_ready, o_i_rvalid, o_d_rvalid, o_mem_req, o_mem_we;
  logic [31:0] o_i_rdata, o_d_rdata, o_mem_addr, o_mem_wdata;
  assign o_i_ready   = sel3 ? b3.i_ready   : b1.i_ready;
  assign o_d_ready   = sel3 ? b3.d_ready   : b1.d_ready;
  assign o_i_rvalid  = sel3 ? b3.i_rvalid  : b1.i_rvalid;
  assign o_d_rvalid  = sel3 ? b3.d_rvalid  : b1.d_rvalid;
  assign o_i_rdata   = sel3 ? b3.i_rdata   : b1.i_rdata;
  assign o_d_rdata   = sel3 ? b3.d_rdata   : b1.d_rdata;
  assign o_mem_req   = sel3 ? b3.mem_req   : b1.mem_req;
  assign o_mem_we    = sel3 ? b3.mem_we    : b1.mem_we;
  assign o_mem_addr  = sel3 ? b3.mem_addr  : b1.mem_addr;
  assign o_mem_wdata = sel3 ? b3.mem_wdata : b1.mem_wdata;

  function automatic logic [31:0] init_word(input int k);
    if (k == 2) return 32'h0010_0093;
    return 32'hA500_0000 ^ (32'(k) * 32'h0101_0101);
  endfunction

  // Memory: read data valid exactly lat cycles after mem_req, random garbage otherwise.
  logic [31:0] mem_arr [0:255];
  logic [31:0] rd_word = '0, junk = '0;
  int          rd_cd = 0;
  logic        mem_ok = 1'b0;
  always @(posedge clk) begin
    junk <= $urandom;
    if (!mem_ok) begin
      for (int k = 0; k < 256; k++) mem_arr[k] <= init_word(k);
      mem_ok <= 1'b1;
    end else if (o_mem_req && o_mem_we) mem_arr[o_mem_addr[9:2]] <= o_mem_wdata;
    if (o_mem_req && !o_mem_we) begin
      rd_word <= mem_arr[o_mem_addr[9:2]];
      rd_cd   <= lat;
    end else if (rd_cd > 0) rd_cd <= rd_cd - 1;
  end
  assign mem_rdata = (rd_cd == 1) ? rd_word : junk;

  int vectors = 0, miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: accept times, completion times and per-port held data.
  int          cyc = 0, next_ok = 0, done_at = 0;
  logic        done_pend = 1'b0, done_d = 1'b0, last_d = 1'b0;
  logic [31:0] done_data = '0, hold_i = '0, hold_d = '0;
  logic [31:0] exp_mem [0:255];

  task automatic step(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                      input logic [31:0] da, input logic [31:0] dd,
                      output logic got_i, output logic got_d);
    logic rv, wi, wd;
    logic [31:0] ei, ed;
    @(negedge clk);
    i_req = ir; i_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
    #2;
    rv = done_pend && (cyc == done_at);
    wi = 1'b0; wd = 1'b0;
    if (cyc >= next_ok && (ir || dr)) begin
      wd = (ir && dr) ? !last_d : dr;
      wi = !wd;
    end
    ei = (rv && !done_d) ? done_data : hold_i;
    ed = (rv &&  done_d) ? done_data : hold_d;
    chk("i_ready", 32'(o_i_ready), 32'(wi));
    chk("d_ready", 32'(o_d_ready), 32'(wd));
    chk("mem_req", 32'(o_mem_req), 32'(wi | wd));
    chk("mem_we", 32'(o_mem_we), 32'(wd & dw));
    if (wi | wd) chk("mem_addr", o_mem_addr, wd ? da : ia);
    if (wd & dw) chk("mem_wdata", o_mem_wdata, dd);
    chk("i_rvalid", 32'(o_i_rvalid), 32'(rv & !done_d));
    chk("d_rvalid", 32'(o_d_rvalid), 32'(rv & done_d));
    chk("i_rdata", o_i_rdata, ei);
    chk("d_rdata", o_d_rdata, ed);
    hold_i = ei; hold_d = ed;
    if (rv) done_pend = 1'b0;
    if (wi | wd) begin
      done_pend = 1'b1;
      done_at   = cyc + lat;
      done_d    = wd;
      done_data = wd ? (dw ? 32'h0 : exp_mem[da[9:2]]) : exp_mem[ia[9:2]];
      if (wd & dw) exp_mem[da[9:2]] = dd;
      last_d  = wd;
      next_ok = cyc + lat + 1;
    end
    cyc++;
    got_i = wi; got_d = wd;
  endtask

  task automatic do_reset();
    @(negedge clk);
    n_reset = 1'b0; i_req = 1'b0; d_req = 1'b0;
    #1;
    chk("rst_i_ready", 32'(o_i_ready), 32'h0);
    chk("rst_d_ready", 32'(o_d_ready), 32'h0);
    chk("rst_i_rvalid", 32'(o_i_rvalid), 32'h0);
    chk("rst_d_rvalid", 32'(o_d_rvalid), 32'h0);
    chk("rst_mem_req", 32'(o_mem_req), 32'h0);
    chk("rst_mem_we", 32'(o_mem_we), 32'h0);
    chk("rst_mem_addr", o_mem_addr, 32'h0);
    chk("rst_mem_wdata", o_mem_wdata, 32'h0);
    chk("rst_i_rdata", o_i_rdata, 32'h0);
    chk("rst_d_rdata", o_d_rdata, 32'h0);
    @(negedge clk);
    n_reset = 1'b1;
    next_ok = cyc; done_pend = 1'b0; last_d = 1'b0; hold_i = '0; hold_d = '0;
  endtask

  task automatic rand_run(input int n);
    logic ion = 1'b0, don = 1'b0, dw = 1'b0, gi, gd;
    logic [31:0] ia = '0, da = '0, dd = '0;
    for (int c = 0; c < n; c++) begin
      if (!ion && $urandom_range(0, 1) == 1) begin
        ion = 1'b1; ia = 32'($urandom_range(0, 255)) << 2;
      end
      if (!don && $urandom_range(0, 2) != 0) begin
        don = 1'b1; dw = 1'($urandom_range(0, 1));
        da = 32'($urandom_range(0, 255)) << 2; dd = $urandom;
      end
      step(ion, ia, don, dw, da, dd, gi, gd);
      if (gi) ion = 1'b0;
      if (gd) don = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic gi, gd;
    n_reset = 1'b0; sel3 = 1'b0;
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    for (int k = 0; k < 256; k++) exp_mem[k] = init_word(k);
    #12;

    // Latency 1: fetch, back-to-back.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, gi, gd);
      if (k == 1) begin
        chk("fetch_rvalid", 32'(o_i_rvalid), 32'h1);
        chk("fetch_rdata", o_i_rdata, 32'h0010_0093);
      end else chk("fetch_accept", 32'(o_i_ready & o_mem_req), 32'h1);
    end

    // Tie after reset: D, I, D, I.
    do_reset();
    for (int k = 0; k < 7; k++) begin
      step(1'b1, 32'h10, 1'b1, 1'b0, 32'h20, 32'h0, gi, gd);
      if (k % 2 == 0)
        chk("tie_gnt", {30'h0, o_i_ready, o_d_ready}, (k % 4 == 0) ? 32'h1 : 32'h2);
    end

    // Request dropped after accept, latency 1.
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0, gi, gd);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h40, 32'h0, gi, gd);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h40, 32'h0, gi, gd);
    rand_run(400);

    // Latency 3: write, fetch stalls through the rvalid cycle.
    sel3 = 1'b1;
    do_reset();
    step(1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, gi, gd);
    chk("wr_mem_we", 32'(o_mem_we), 32'h1);
    for (int k = 1; k <= 4; k++) begin
      step(1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 32'h0, gi, gd);
      if (k == 3) begin
        chk("wr_d_rvalid", 32'(o_d_rvalid), 32'h1);
        chk("wr_d_rdata", o_d_rdata, 32'h0);
      end
    end
    for (int k = 0; k < 3; k++) step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, gi, gd);

    // Read-back of the written word, then drop the request after accept.
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0, gi, gd);
    for (int k = 1; k <= 3; k++) step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, gi, gd);
    chk("rb_d_rdata", o_d_rdata, 32'hDEAD_BEEF);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, gi, gd);

    // Reset in flight: rvalid dropped, fetch accepted right after release.
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h44, 32'h0, gi, gd);
    do_reset();
    step(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, gi, gd);
    chk("post_rst_accept", 32'(o_i_ready), 32'h1);
    for (int k = 0; k < 4; k++) step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, gi, gd);
    rand_run(400);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-port unified memory between the CPU's instruction-fetch port and its load/store port. It sits between `cpu` and the program/data memory, so the ROM/RAM pair collapses into a single array. It grants one requester at a time, issues the access to memory, and returns read data or write completion after a fixed memory latency. Every other requester stalls until it is granted.

## Interface
Parameters:
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `MEM_LATENCY`, default 1: cycles from `mem_req` to valid `mem_rdata`. Legal range 1..4.

Ports:
- `clk`  in  1: single clock, rising edge.
- `n_reset`  in  1: asynchronous, active-low reset.
- `i_req`  in  1: fetch request. Held with `i_addr` until `i_ready`.
- `i_addr`  in  ADDR_W: fetch address.
- `i_ready`  out  1: fetch accepted this cycle.
- `i_rvalid`  out  1: one-cycle pulse; `i_rdata` is valid.
- `i_rdata`  out  DATA_W: instruction word.
- `d_req`  in  1: data request. Held with `d_we`/`d_addr`/`d_wdata` until `d_ready`.
- `d_we`  in  1: 1 = write, 0 = read.
- `d_addr`  in  ADDR_W: data address.
- `d_wdata`  in  DATA_W: write data.
- `d_ready`  out  1: data request accepted this cycle.
- `d_rvalid`  out  1: one-cycle pulse; read data valid, or write complete.
- `d_rdata`  out  DATA_W: load data. 0 for writes.
- `mem_req`  out  1: memory access strobe, exactly one cycle per transaction.
- `mem_we`  out  1: write enable. Only asserted together with `mem_req`.
- `mem_addr`  out  ADDR_W: memory address.
- `mem_wdata`  out  DATA_W: memory write data.
- `mem_rdata`  in  DATA_W: memory read data. Valid `MEM_LATENCY` cycles after `mem_req`.

## Operation
- FSM states:
  - `ARB_IDLE`: no transaction outstanding.
  - `ARB_BUSY`: one transaction in flight.
  - At most one transaction is outstanding at any time.
- In `ARB_IDLE` with any request pending:
  - Arbitration is combinational.
  - `mem_req` and the winner's `x_ready` are asserted in the same cycle, with `mem_addr`/`mem_we`/`mem_wdata` muxed from the winner.
  - Next state is `ARB_BUSY`; winner is latched in `gnt_q`; latency counter is loaded with `MEM_LATENCY`.
- Arbitration:
  - A single requester is granted immediately.
  - If both request, round-robin decides: the port not granted last wins.
  - `last_q` resets to I, so D wins the first tie.
- In `ARB_BUSY`:
  - Counter decrements each cycle.
  - In the cycle the counter reaches 1, the arbiter pulses `x_rvalid` for `gnt_q`, drives `x_rdata = mem_rdata` (reads), and returns to `ARB_IDLE`.
- Outside their `rvalid` cycle, `i_rdata`/`d_rdata` hold their last value (registered capture, 0 after reset).
- A requester that drops `req` after `ready` still receives its `rvalid`. The transaction is never cancelled.
- Requests arriving during `ARB_BUSY` see `ready = 0` and wait.
- Counter width is `$clog2(MEM_LATENCY+1)`. It saturates at 0 and never wraps.

## Timing
- Reset values:
  - `i_ready`, `d_ready`, `i_rvalid`, `d_rvalid`, `mem_req`, `mem_we` = 0.
  - `mem_addr`, `mem_wdata`, `i_rdata`, `d_rdata` = 0.
  - State `ARB_IDLE`, `last_q` = I, counter = 0.
- Accept at cycle t leads to `rvalid` at t+`MEM_LATENCY`.
  - The earliest next accept is t+`MEM_LATENCY`+1.
  - Peak throughput is one transaction per `MEM_LATENCY`+1 cycles.
- The `rvalid` cycle is never also an accept cycle, by design. This gives the single-cycle `cpu` a clean stall boundary.
- Reset asserted mid-transaction:
  - All outputs go to reset values immediately (asynchronous).
  - The in-flight `rvalid` is dropped.
  - After `n_reset` deasserts, the next access starts from `ARB_IDLE`.
- Simultaneous `i_req` and `d_req` arriving in the `rvalid` cycle are both deferred to the next cycle, then resolved by round-robin.

## Structure
- Package `mem_arb_pkg`:
  - `typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t`.
  - `typedef enum logic {GNT_I, GNT_D} arb_gnt_t`.
  - `localparam MAX_MEM_LATENCY = 4`.
- Sub-module `arb_rr2`: two-input round-robin picker. Inputs are `req_i`, `req_d` and `last`; output is `arb_gnt_t`. Purely combinational.
- `mem_arbiter` owns the FSM, counter, `last_q`/`gnt_q` registers and output muxing.
- Assertion on `MEM_LATENCY` range at elaboration.

## Test plan
- Fetch only, `MEM_LATENCY`=1:
  - Stimulus: `i_req`=1, `i_addr`=0x8; memory returns 0x00100093.
  - Required: `i_ready` and `mem_req` at t; `i_rvalid` with `i_rdata`=0x00100093 at t+1; next accept at t+2.
- Tie after reset:
  - Stimulus: `i_req`=`d_req`=1 in the first cycle after reset.
  - Required: D granted first, I granted at t+`MEM_LATENCY`+1.
  - With both held high, grants then alternate I, D, I.
- Write, `MEM_LATENCY`=3:
  - Stimulus: `d_we`=1, `d_addr`=0x100, `d_wdata`=0xDEADBEEF.
  - Required: `mem_we`=1 only at t; `d_rvalid` at t+3 with `d_rdata`=0; `i_ready` stays 0 through t+3.
- Request dropped after accept:
  - Stimulus: `d_req` deasserted at t+1.
  - Required: `d_rvalid` still pulses at t+`MEM_LATENCY`; no second `mem_req`.
- Reset mid-flight, `MEM_LATENCY`=3:
  - Stimulus: `n_reset`=0 at t+1.
  - Required: no `rvalid`, all outputs 0 immediately.
  - After release, `i_req` is accepted in the first cycle.
